// File: rtl/cache_port_arbiter.sv
// Purpose: shares one byte-wide cache controller between the fetch port (0) and the load/store port (1).
// Latency: accept at T, cache request at T+1, read data at T+3 on a hit, write done at T+4 on a hit.
// Backpressure: one request in flight system-wide; port ready is low outside IDLE, the cache request holds until c_req_ready.
module cache_port_arbiter #(
    parameter int Addresswidth  = 27,
    parameter bit FixedPriority = 1'b0
) (
    input  logic                    clk,
    input  logic                    rstn,
    // port 0: instruction fetch
    input  logic                    p0_req_valid,
    output logic                    p0_req_ready,
    input  logic [Addresswidth-1:0] p0_addr,
    input  logic [7:0]              p0_data,
    input  logic                    p0_wr,
    output logic                    p0_rsp_valid,
    output logic [7:0]              p0_rsp_data,
    output logic                    p0_wr_done,
    // port 1: load/store
    input  logic                    p1_req_valid,
    output logic                    p1_req_ready,
    input  logic [Addresswidth-1:0] p1_addr,
    input  logic [7:0]              p1_data,
    input  logic                    p1_wr,
    output logic                    p1_rsp_valid,
    output logic [7:0]              p1_rsp_data,
    output logic                    p1_wr_done,
    // cache side
    output logic                    c_req_valid,
    input  logic                    c_req_ready,
    output logic [Addresswidth-1:0] c_addr,
    output logic [7:0]              c_data,
    output logic                    c_wr,
    input  logic                    c_rsp_valid,
    input  logic [7:0]              c_rsp_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    // holding registers for the single outstanding request
    logic [Addresswidth-1:0] r_addr;
    logic [7:0]              r_data;
    logic                    r_wr;       // 1 = read, 0 = write (cache encoding)
    logic                    r_owner;    // port that owns the outstanding request
    logic                    r_last_grant;

    // per-port response registers
    logic                    r_p0_rsp_valid;
    logic [7:0]              r_p0_rsp_data;
    logic                    r_p0_wr_done;
    logic                    r_p1_rsp_valid;
    logic [7:0]              r_p1_rsp_data;
    logic                    r_p1_wr_done;

    logic                    w_grant_vld;
    logic                    w_grant;    // winning port index
    logic                    w_rsp_fire;
    logic                    w_wr_fire;

    // Pick a winner in IDLE; on a tie the port that was not granted last wins unless port 0 is fixed-priority.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = 1'b0;
        if (r_state == IDLE) begin
            if (p0_req_valid && p1_req_valid) begin
                w_grant_vld = 1'b1;
                w_grant     = FixedPriority ? 1'b0 : ~r_last_grant;
            end else if (p0_req_valid) begin
                w_grant_vld = 1'b1;
                w_grant     = 1'b0;
            end else if (p1_req_valid) begin
                w_grant_vld = 1'b1;
                w_grant     = 1'b1;
            end
        end
    end

    // Completion events: read data arrives, or the cache returns to idle after a write.
    // Stray c_rsp_valid outside a read wait and c_req_ready during a read wait are ignored.
    always_comb begin
        w_rsp_fire = (r_state == WAIT) &&  r_wr && c_rsp_valid;
        w_wr_fire  = (r_state == WAIT) && !r_wr && c_req_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and control outputs.
    always_comb begin
        w_next_state = r_state;
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        c_req_valid  = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy         = 1'b0;
                p0_req_ready = w_grant_vld && !w_grant;
                p1_req_ready = w_grant_vld &&  w_grant;
                if (w_grant_vld) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                c_req_valid = 1'b1;
                if (c_req_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (w_rsp_fire || w_wr_fire) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latch the winning request and remember who was granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr       <= '0;
            r_data       <= '0;
            r_wr         <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;   // makes port 0 win the first tie
        end else if (w_grant_vld) begin
            r_addr       <= w_grant ? p1_addr : p0_addr;
            r_data       <= w_grant ? p1_data : p0_data;
            r_wr         <= w_grant ? p1_wr   : p0_wr;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
        end
    end

    // Route completions back to the owning port as one-cycle pulses; read data holds between responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_p0_rsp_valid <= 1'b0;
            r_p0_rsp_data  <= '0;
            r_p0_wr_done   <= 1'b0;
            r_p1_rsp_valid <= 1'b0;
            r_p1_rsp_data  <= '0;
            r_p1_wr_done   <= 1'b0;
        end else begin
            r_p0_rsp_valid <= w_rsp_fire && !r_owner;
            r_p1_rsp_valid <= w_rsp_fire &&  r_owner;
            r_p0_wr_done   <= w_wr_fire  && !r_owner;
            r_p1_wr_done   <= w_wr_fire  &&  r_owner;
            if (w_rsp_fire && !r_owner) begin
                r_p0_rsp_data <= c_rsp_data;
            end
            if (w_rsp_fire && r_owner) begin
                r_p1_rsp_data <= c_rsp_data;
            end
        end
    end

    assign c_addr       = r_addr;
    assign c_data       = r_data;
    assign c_wr         = r_wr;
    assign p0_rsp_valid = r_p0_rsp_valid;
    assign p0_rsp_data  = r_p0_rsp_data;
    assign p0_wr_done   = r_p0_wr_done;
    assign p1_rsp_valid = r_p1_rsp_valid;
    assign p1_rsp_data  = r_p1_rsp_data;
    assign p1_wr_done   = r_p1_wr_done;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: a behavioural cache (hit/miss/stall) behind the round-robin instance,
// plus a fixed-priority instance behind an always-ready cache stub that shares the port inputs.
// Directed scenarios with hand-computed expected values; inputs driven 2ns after the rising edge, outputs sampled on the falling edge.
module tb_cache_port_arbiter;

    localparam int AW = 27;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;

    logic          p0_req_valid = 1'b0, p1_req_valid = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [7:0]    p0_data = '0, p1_data = '0;
    logic          p0_wr = 1'b0, p1_wr = 1'b0;

    logic          p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_wr_done, p1_wr_done;
    logic [7:0]    p0_rsp_data, p1_rsp_data;
    logic          c_req_valid, c_req_ready, c_wr, c_rsp_valid, busy;
    logic [AW-1:0] c_addr;
    logic [7:0]    c_data, c_rsp_data;

    logic          f_p0_req_ready, f_p1_req_ready, f_p0_rsp_valid, f_p1_rsp_valid, f_p0_wr_done, f_p1_wr_done;
    logic [7:0]    f_p0_rsp_data, f_p1_rsp_data, f_c_data;
    logic          f_c_req_valid, f_c_wr, f_busy;
    logic [AW-1:0] f_c_addr;

    int            checks = 0;
    int            errors = 0;

    // cache model controls
    logic          cache_block = 1'b0;
    int            miss_cycles = 0;

    always #5 clk = ~clk;

    cache_port_arbiter #(.Addresswidth(AW), .FixedPriority(1'b0)) u_dut (
        .clk(clk), .rstn(rstn),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr), .p0_data(p0_data),
        .p0_wr(p0_wr), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data), .p0_wr_done(p0_wr_done),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr), .p1_data(p1_data),
        .p1_wr(p1_wr), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data), .p1_wr_done(p1_wr_done),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_addr(c_addr), .c_data(c_data), .c_wr(c_wr),
        .c_rsp_valid(c_rsp_valid), .c_rsp_data(c_rsp_data), .busy(busy)
    );

    cache_port_arbiter #(.Addresswidth(AW), .FixedPriority(1'b1)) u_dut_fp (
        .clk(clk), .rstn(rstn),
        .p0_req_valid(p0_req_valid), .p0_req_ready(f_p0_req_ready), .p0_addr(p0_addr), .p0_data(p0_data),
        .p0_wr(p0_wr), .p0_rsp_valid(f_p0_rsp_valid), .p0_rsp_data(f_p0_rsp_data), .p0_wr_done(f_p0_wr_done),
        .p1_req_valid(p1_req_valid), .p1_req_ready(f_p1_req_ready), .p1_addr(p1_addr), .p1_data(p1_data),
        .p1_wr(p1_wr), .p1_rsp_valid(f_p1_rsp_valid), .p1_rsp_data(f_p1_rsp_data), .p1_wr_done(f_p1_wr_done),
        .c_req_valid(f_c_req_valid), .c_req_ready(1'b1), .c_addr(f_c_addr), .c_data(f_c_data), .c_wr(f_c_wr),
        .c_rsp_valid(1'b1), .c_rsp_data(8'h00), .busy(f_busy)
    );

    // Behavioural cache: 0 idle, 1 read response, 2 write in progress, 3 miss fill.
    logic [7:0]    mem [256];
    int            m_state;
    int            m_cnt;
    logic [7:0]    m_rdata;

    assign c_req_ready = (m_state == 0) && !cache_block;
    assign c_rsp_valid = (m_state == 1);
    assign c_rsp_data  = (m_state == 1) ? m_rdata : 8'h00;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_rdata <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem[8'h10] <= 8'hA5;
            mem[8'h30] <= 8'h7E;
        end else begin
            case (m_state)
                0: if (c_req_valid && c_req_ready) begin
                    if (c_wr) begin
                        m_rdata <= mem[c_addr[7:0]];
                        if (miss_cycles > 0) begin
                            m_state <= 3;
                            m_cnt   <= miss_cycles;
                        end else begin
                            m_state <= 1;
                        end
                    end else begin
                        mem[c_addr[7:0]] <= c_data;
                        m_state <= 2;
                    end
                end
                1: m_state <= 0;
                2: m_state <= 0;
                3: if (m_cnt <= 1) m_state <= 1; else m_cnt <= m_cnt - 1;
                default: m_state <= 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        checks++;
        if ({busy, c_req_valid, c_wr, p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_wr_done, p1_wr_done} !== 9'b0
            || c_addr !== '0 || c_data !== 8'h00 || p0_rsp_data !== 8'h00 || p1_rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b cvld=%b caddr=%h cdata=%h p0d=%h p1d=%h, required all zero",
                     busy, c_req_valid, c_addr, c_data, p0_rsp_data, p1_rsp_data);
        end
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    task automatic test_read_hit();
        step();
        p0_req_valid = 1'b1; p0_addr = 27'h10; p0_wr = 1'b1; p0_data = 8'h00;
        @(negedge clk);  // T
        checks++;
        if ({p0_req_ready, p1_req_ready, c_req_valid} !== 3'b100) begin
            errors++; $display("FAIL rd_accept: {r0,r1,cvld}=%b, required 100", {p0_req_ready, p1_req_ready, c_req_valid});
        end
        step(); p0_req_valid = 1'b0;
        @(negedge clk);  // T+1
        checks++;
        if ({c_req_valid, c_wr} !== 2'b11 || c_addr !== 27'h10) begin
            errors++; $display("FAIL rd_issue: cvld=%b cwr=%b caddr=%h, required 1 1 0000010", c_req_valid, c_wr, c_addr);
        end
        step(); @(negedge clk);  // T+2
        checks++;
        if ({c_req_valid, busy, p0_rsp_valid} !== 3'b010) begin
            errors++; $display("FAIL rd_wait: {cvld,busy,rv0}=%b, required 010", {c_req_valid, busy, p0_rsp_valid});
        end
        step(); @(negedge clk);  // T+3
        checks++;
        if ({p0_rsp_valid, p1_rsp_valid, p0_wr_done, p1_wr_done} !== 4'b1000 || p0_rsp_data !== 8'hA5
            || p1_rsp_data !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL rd_resp: pulses=%b d0=%h d1=%h busy=%b, required 1000 a5 00 0",
                               {p0_rsp_valid, p1_rsp_valid, p0_wr_done, p1_wr_done}, p0_rsp_data, p1_rsp_data, busy);
        end
        step(); @(negedge clk);  // T+4
        checks++;
        if (p0_rsp_valid !== 1'b0 || p0_rsp_data !== 8'hA5) begin
            errors++; $display("FAIL rd_hold: rv0=%b d0=%h, required 0 a5", p0_rsp_valid, p0_rsp_data);
        end
    endtask

    task automatic test_write();
        step();
        p1_req_valid = 1'b1; p1_addr = 27'h20; p1_wr = 1'b0; p1_data = 8'h3C;
        @(negedge clk);  // T
        checks++;
        if ({p0_req_ready, p1_req_ready} !== 2'b01) begin
            errors++; $display("FAIL wr_accept: {r0,r1}=%b, required 01", {p0_req_ready, p1_req_ready});
        end
        step(); p1_req_valid = 1'b0;
        @(negedge clk);  // T+1
        checks++;
        if ({c_req_valid, c_wr} !== 2'b10 || c_data !== 8'h3C || c_addr !== 27'h20) begin
            errors++; $display("FAIL wr_issue: cvld=%b cwr=%b cdata=%h caddr=%h, required 1 0 3c 0000020",
                               c_req_valid, c_wr, c_data, c_addr);
        end
        for (int k = 2; k <= 3; k++) begin
            step(); @(negedge clk);  // T+2, T+3
            checks++;
            if ({p1_wr_done, p1_rsp_valid, busy} !== 3'b001) begin
                errors++; $display("FAIL wr_early T+%0d: {wd1,rv1,busy}=%b, required 001", k, {p1_wr_done, p1_rsp_valid, busy});
            end
        end
        step(); @(negedge clk);  // T+4
        checks++;
        if ({p0_rsp_valid, p1_rsp_valid, p0_wr_done, p1_wr_done} !== 4'b0001) begin
            errors++; $display("FAIL wr_done: pulses=%b, required 0001", {p0_rsp_valid, p1_rsp_valid, p0_wr_done, p1_wr_done});
        end
        step(); @(negedge clk);  // T+5
        checks++;
        if (p1_wr_done !== 1'b0) begin
            errors++; $display("FAIL wr_done_pulse: wd1=%b, required 0", p1_wr_done);
        end
        // read the byte back through port 1
        step();
        p1_req_valid = 1'b1; p1_addr = 27'h20; p1_wr = 1'b1;
        @(negedge clk);
        step(); p1_req_valid = 1'b0;
        step(); step(); @(negedge clk);  // T+3 of the read
        checks++;
        if (p1_rsp_valid !== 1'b1 || p1_rsp_data !== 8'h3C || p0_rsp_data !== 8'hA5) begin
            errors++; $display("FAIL wr_readback: rv1=%b d1=%h d0=%h, required 1 3c a5", p1_rsp_valid, p1_rsp_data, p0_rsp_data);
        end
    endtask

    task automatic test_stall();
        cache_block = 1'b1;
        step();
        p0_req_valid = 1'b1; p0_addr = 27'h10; p0_wr = 1'b1; p0_data = 8'h55;
        @(negedge clk);  // T
        checks++;
        if (p0_req_ready !== 1'b1) begin
            errors++; $display("FAIL stall_accept: r0=%b, required 1", p0_req_ready);
        end
        step(); p0_req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (c_req_valid !== 1'b1 || c_addr !== 27'h10 || c_data !== 8'h55 || c_wr !== 1'b1) begin
                errors++; $display("FAIL stall_hold T+%0d: cvld=%b caddr=%h cdata=%h cwr=%b, required 1 0000010 55 1",
                                   k, c_req_valid, c_addr, c_data, c_wr);
            end
            step();
        end
        cache_block = 1'b0;
        @(negedge clk);  // T+6: first ready cycle
        checks++;
        if ({c_req_valid, c_req_ready} !== 2'b11) begin
            errors++; $display("FAIL stall_release: {cvld,crdy}=%b, required 11", {c_req_valid, c_req_ready});
        end
        step(); @(negedge clk);  // T+7
        checks++;
        if ({c_req_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL stall_accepted: {cvld,busy}=%b, required 01", {c_req_valid, busy});
        end
        step(); @(negedge clk);  // T+8
        checks++;
        if (p0_rsp_valid !== 1'b1 || p0_rsp_data !== 8'hA5) begin
            errors++; $display("FAIL stall_resp: rv0=%b d0=%h, required 1 a5", p0_rsp_valid, p0_rsp_data);
        end
    endtask

    task automatic test_miss();
        int         npulse = 0;
        int         p1act = 0;
        int         busylow = 0;
        logic [7:0] got = 8'h00;
        miss_cycles = 20;
        step();
        p0_req_valid = 1'b1; p0_addr = 27'h30; p0_wr = 1'b1;
        @(negedge clk);
        step(); p0_req_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (p0_rsp_valid) begin
                npulse++;
                got = p0_rsp_data;
            end else if (npulse == 0 && !busy) begin
                busylow++;
            end
            if (p1_rsp_valid || p1_wr_done || p1_req_ready) p1act++;
            step();
        end
        miss_cycles = 0;
        checks++;
        if (npulse != 1 || got !== 8'h7E) begin
            errors++; $display("FAIL miss_resp: pulses=%0d data=%h, required 1 7e", npulse, got);
        end
        checks++;
        if (p1act != 0 || busylow != 0) begin
            errors++; $display("FAIL miss_side: p1 activity=%0d busy-low cycles=%0d, required 0 0", p1act, busylow);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] seq = 4'b0;
        int         ng = 0;
        int         both = 0;
        int         fp0 = 0;
        int         fp1 = 0;
        // fresh reset so the first tie goes to port 0
        step(); rstn = 1'b0;
        step(); rstn = 1'b1;
        p0_req_valid = 1'b1; p0_addr = 27'h10; p0_wr = 1'b1;
        p1_req_valid = 1'b1; p1_addr = 27'h20; p1_wr = 1'b1;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (p0_req_ready && p1_req_ready) both++;
            if (p0_req_ready) begin
                seq[3-ng] = 1'b0; ng++;
            end else if (p1_req_ready) begin
                seq[3-ng] = 1'b1; ng++;
            end
            if (f_p0_req_ready) fp0++;
            if (f_p1_req_ready) fp1++;
            step();
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        checks++;
        if (ng != 4 || seq !== 4'b0101 || both != 0) begin
            errors++; $display("FAIL rr_grants: count=%0d order=%b dual=%0d, required 4 0101 0", ng, seq, both);
        end
        checks++;
        if (fp0 != 4 || fp1 != 0) begin
            errors++; $display("FAIL fixed_grants: p0=%0d p1=%0d, required 4 0", fp0, fp1);
        end
        repeat (5) step();
        @(negedge clk);
        checks++;
        if ({busy, f_busy} !== 2'b00) begin
            errors++; $display("FAIL arb_drain: {busy,fbusy}=%b, required 00", {busy, f_busy});
        end
    endtask

    task automatic test_reset_mid();
        int         wd = 0;
        int         seen = 0;
        logic [7:0] got = 8'h00;
        step();
        p1_req_valid = 1'b1; p1_addr = 27'h40; p1_wr = 1'b0; p1_data = 8'h99;
        @(negedge clk);  // T
        step(); p1_req_valid = 1'b0;
        step();
        @(negedge clk);  // T+2: write outstanding in WAIT
        checks++;
        if ({busy, c_req_valid} !== 2'b10) begin
            errors++; $display("FAIL rm_wait: {busy,cvld}=%b, required 10", {busy, c_req_valid});
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({busy, c_req_valid, c_wr, p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_wr_done, p1_wr_done} !== 9'b0
            || c_addr !== '0 || c_data !== 8'h00 || p0_rsp_data !== 8'h00 || p1_rsp_data !== 8'h00) begin
            errors++; $display("FAIL rm_outputs: busy=%b cvld=%b caddr=%h cdata=%h d0=%h d1=%h, required all zero",
                               busy, c_req_valid, c_addr, c_data, p0_rsp_data, p1_rsp_data);
        end
        cache_block = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (p1_wr_done) wd++;
        end
        step(); rstn = 1'b1;
        p0_req_valid = 1'b1; p0_addr = 27'h10; p0_wr = 1'b1;
        @(negedge clk);
        if (p1_wr_done) wd++;
        step(); p0_req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (p1_wr_done) wd++;
            checks++;
            if ({c_req_valid, busy, p0_rsp_valid} !== 3'b110) begin
                errors++; $display("FAIL rm_blocked %0d: {cvld,busy,rv0}=%b, required 110", c, {c_req_valid, busy, p0_rsp_valid});
            end
            step();
        end
        cache_block = 1'b0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (p1_wr_done) wd++;
            if (p0_rsp_valid) begin
                seen = 1;
                got = p0_rsp_data;
            end
            step();
        end
        checks++;
        if (seen != 1 || got !== 8'hA5) begin
            errors++; $display("FAIL rm_after: response seen=%0d data=%h, required 1 a5", seen, got);
        end
        checks++;
        if (wd != 0) begin
            errors++; $display("FAIL rm_no_wr_done: wr_done pulses=%0d, required 0", wd);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write();
        test_stall();
        test_miss();
        test_arbitration();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
